// File: rtl/psg_mixdown.sv
`default_nettype none
// =============================================================================
// Module      : psg_mixdown
// Description : Sums the two PSG outputs, decimates by 2^LOG2DIV, DC-blocks
//               and saturates into a 16-bit signed PCM stream with a strobe.
// Revision    : 1.0 - initial release
// =============================================================================
module psg_mixdown #(
  parameter int LOG2DIV = 4,
  parameter int DCK     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in0,
  input  logic [7:0]         in1,
  input  logic [1:0]         mute,
  input  logic               dcbyp,
  output logic signed [15:0] sout,
  output logic               svld
);

  localparam int AW = 9 + LOG2DIV;

  // Stage A: window counter, accumulator and window mean
  logic [LOG2DIV-1:0] cnt_q,   cnt_d;
  logic [AW-1:0]      acc_q,   acc_d;
  logic [8:0]         avg_q,   avg_d;
  logic               va_q,    va_d;

  // Stage B: differentiator history, leaky integrator and output registers
  logic signed [16:0] xprev_q, xprev_d;
  logic signed [27:0] yacc_q,  yacc_d;
  logic               first_q, first_d;
  logic signed [15:0] sout_q,  sout_d;
  logic               svld_q,  svld_d;

  logic [8:0]         w_sum;
  logic [AW-1:0]      w_acc_sum;
  logic               w_wrap;
  logic signed [16:0] w_x;
  logic signed [17:0] w_d;
  logic signed [27:0] w_dsh;
  logic signed [27:0] w_leak;
  logic signed [27:0] w_yacc_nx;
  logic signed [19:0] w_y;
  logic signed [15:0] w_ysat;
  logic signed [15:0] w_byp;

  always_comb begin
    w_sum     = (mute[0] ? 9'd0 : {1'b0, in0}) + (mute[1] ? 9'd0 : {1'b0, in1});
    w_acc_sum = acc_q + AW'(w_sum);
    w_wrap    = (cnt_q == {LOG2DIV{1'b1}});
  end

  always_comb begin
    w_x       = $signed({1'b0, avg_q, 7'd0});
    // The very first sample only seeds the history so power-up gives no step
    w_d       = first_q ? 18'sd0
                        : ($signed({w_x[16], w_x}) - $signed({xprev_q[16], xprev_q}));
    w_dsh     = $signed({{2{w_d[17]}}, w_d, 8'd0});
    w_leak    = yacc_q >>> DCK;
    w_yacc_nx = yacc_q + w_dsh - w_leak;
    w_y       = w_yacc_nx[27:8];
    if (w_y > 20'sd32767) begin
      w_ysat = 16'sh7fff;
    end else if (w_y < -20'sd32768) begin
      w_ysat = 16'sh8000;
    end else begin
      w_ysat = w_y[15:0];
    end
    w_byp     = $signed({1'b0, avg_q, 6'd0}) - 16'sd16384;
  end

  always_comb begin
    cnt_d   = cnt_q + LOG2DIV'(1);
    acc_d   = w_wrap ? '0 : w_acc_sum;
    avg_d   = w_wrap ? w_acc_sum[AW-1:LOG2DIV] : avg_q;
    va_d    = w_wrap;
    xprev_d = xprev_q;
    yacc_d  = yacc_q;
    first_d = first_q;
    sout_d  = sout_q;
    svld_d  = va_q;
    // The filter keeps running in bypass so leaving bypass causes no jump
    if (va_q) begin
      xprev_d = w_x;
      yacc_d  = w_yacc_nx;
      first_d = 1'b0;
      sout_d  = dcbyp ? w_byp : w_ysat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      avg_q   <= '0;
      va_q    <= 1'b0;
      xprev_q <= '0;
      yacc_q  <= '0;
      first_q <= 1'b1;
      sout_q  <= '0;
      svld_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      avg_q   <= avg_d;
      va_q    <= va_d;
      xprev_q <= xprev_d;
      yacc_q  <= yacc_d;
      first_q <= first_d;
      sout_q  <= sout_d;
      svld_q  <= svld_d;
    end
  end

  assign sout = sout_q;
  assign svld = svld_q;

endmodule
`default_nettype wire

// File: tb/tb_psg_mixdown.sv
`default_nettype none
// =============================================================================
// Module      : tb_psg_mixdown
// Description : Scoreboard bench running three decimation widths side by side
//               against an arithmetic reference of the mixdown path.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_psg_mixdown;

  localparam int DCK  = 8;
  localparam int NDUT = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [7:0]         in0;
  logic [7:0]         in1;
  logic [1:0]         mute;
  logic               dcbyp;
  logic signed [15:0] sout_w [NDUT];
  logic               svld_w [NDUT];

  always #5 clk = ~clk;

  psg_mixdown #(.LOG2DIV(4), .DCK(DCK)) u_dut0 (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .mute(mute), .dcbyp(dcbyp),
    .sout(sout_w[0]), .svld(svld_w[0]));
  psg_mixdown #(.LOG2DIV(1), .DCK(DCK)) u_dut1 (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .mute(mute), .dcbyp(dcbyp),
    .sout(sout_w[1]), .svld(svld_w[1]));
  psg_mixdown #(.LOG2DIV(8), .DCK(DCK)) u_dut2 (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .mute(mute), .dcbyp(dcbyp),
    .sout(sout_w[2]), .svld(svld_w[2]));

  typedef struct {
    int     ccount;
    int     acc;
    int     avg;
    bit     pend;
    bit     first;
    longint xprev;
    longint yacc;
  } mdl_t;

  typedef struct {
    int val;
    int edge_n;
  } exp_t;

  mdl_t m [NDUT];
  int   lg [NDUT] = '{4, 1, 8};
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   hist0[$];
  int   last_sout [NDUT];
  int   last_val  [NDUT];
  int   last_edge [NDUT];
  int   period    [NDUT];
  int   edge_n   = 0;
  bit   started  = 1'b0;
  bit   rst_last = 1'b0;
  bit   alt      = 1'b0;
  int   passed   = 0;
  int   total    = 0;

  task automatic chk(string name, int act, int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, expv, edge_n);
  endtask

  function automatic longint fdiv(longint a, longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic q_push(int k, exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int q_size(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_pop(int k, output exp_t e);
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic q_clear(int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Reference: window means, then a floor-exact leaky differentiator
  task automatic model_edge(int k);
    int     n;
    int     s;
    longint x;
    longint d;
    longint y;
    exp_t   e;
    n = 1 << lg[k];
    s = (mute[0] ? 0 : int'(in0)) + (mute[1] ? 0 : int'(in1));
    if (m[k].pend) begin
      x = longint'(m[k].avg) * 128;
      if (m[k].first) begin
        d = 0;
        m[k].first = 1'b0;
      end else begin
        d = x - m[k].xprev;
      end
      m[k].xprev = x;
      m[k].yacc  = m[k].yacc + d * 256 - fdiv(m[k].yacc, longint'(1) << DCK);
      y = fdiv(m[k].yacc, 256);
      if (y > 32767)  y = 32767;
      if (y < -32768) y = -32768;
      e.val    = dcbyp ? (m[k].avg * 64 - 16384) : int'(y);
      e.edge_n = edge_n;
      q_push(k, e);
      m[k].pend = 1'b0;
    end
    if (m[k].ccount % n == n - 1) begin
      m[k].avg  = (m[k].acc + s) / n;
      m[k].acc  = 0;
      m[k].pend = 1'b1;
    end else begin
      m[k].acc += s;
    end
    m[k].ccount++;
  endtask

  initial forever begin
    @(posedge clk);
    edge_n++;
    if (reset === 1'b1) begin
      started  = 1'b1;
      rst_last = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
        m[k].ccount = 0;
        m[k].acc    = 0;
        m[k].avg    = 0;
        m[k].pend   = 1'b0;
        m[k].first  = 1'b1;
        m[k].xprev  = 0;
        m[k].yacc   = 0;
        q_clear(k);
        last_sout[k] = 0;
        last_edge[k] = -1;
        period[k]    = 0;
      end
    end else if (started) begin
      rst_last = 1'b0;
      for (int k = 0; k < NDUT; k++) model_edge(k);
    end
  end

  task automatic mon(int k);
    exp_t e;
    if (rst_last) begin
      chk($sformatf("rst_svld%0d", k), int'(svld_w[k]), 0);
      chk($sformatf("rst_sout%0d", k), int'(sout_w[k]), 0);
      return;
    end
    if (svld_w[k] === 1'b1) begin
      chk($sformatf("strobe_expected%0d", k), int'(q_size(k) > 0), 1);
      if (q_size(k) > 0) begin
        q_pop(k, e);
        chk($sformatf("sout_value%0d", k), int'(sout_w[k]), e.val);
      end
      if (last_edge[k] >= 0) period[k] = edge_n - last_edge[k];
      last_edge[k] = edge_n;
      last_sout[k] = int'(sout_w[k]);
      last_val[k]  = int'(sout_w[k]);
      if (k == 0) hist0.push_back(int'(sout_w[k]));
    end else begin
      if (q_size(k) > 0) begin
        q_pop(k, e);
        chk($sformatf("strobe_missing%0d", k), int'(svld_w[k]), 1);
      end
      chk($sformatf("sout_hold%0d", k), int'(sout_w[k]), last_sout[k]);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (started) for (int k = 0; k < NDUT; k++) mon(k);
  end

  task automatic tick();
    @(negedge clk);
    if (alt) in0 = (in0 == 8'd0) ? 8'd200 : 8'd0;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic wait_phase(int ph);
    int n;
    n = 0;
    while ((m[0].ccount % 16 != ph) && (n < 64)) begin
      tick();
      n++;
    end
    chk("phase_reached", m[0].ccount % 16, ph);
  endtask

  // Changes both inputs at a window start and drops the old window's strobe
  task automatic step_to(logic [7:0] v);
    in0 = v;
    in1 = v;
    @(negedge clk);
    #1;
    hist0.delete();
  endtask

  int found;

  initial begin
    reset = 1'b1;
    in0   = 8'd100;
    in1   = 8'd100;
    mute  = 2'b00;
    dcbyp = 1'b1;

    // Bypass at all three decimation widths
    do_reset(3);
    run(600);
    chk("byp_val_l4", last_val[0], -3584);
    chk("byp_val_l1", last_val[1], -3584);
    chk("byp_val_l8", last_val[2], -3584);
    chk("period_l4", period[0], 16);
    chk("period_l1", period[1], 2);
    chk("period_l8", period[2], 256);

    // Constant input through the DC blocker must stay silent
    dcbyp = 1'b0;
    do_reset(2);
    hist0.delete();
    run(200);
    chk("nopop_count", int'(hist0.size() >= 10), 1);
    foreach (hist0[i]) chk("nopop_val", hist0[i], 0);

    // Step 0 -> 64 and decay
    in0 = 8'd0;
    in1 = 8'd0;
    do_reset(2);
    run(64);
    wait_phase(0);
    step_to(8'd64);
    run(16 * 20);
    if (hist0.size() >= 2) begin
      chk("step_first", hist0[0], 16384);
      chk("step_second", hist0[1], 16320);
    end else chk("step_count", hist0.size(), 2);
    for (int i = 1; i < hist0.size(); i++) begin
      chk("step_mono", int'(hist0[i] <= hist0[i-1]), 1);
      chk("step_pos", int'(hist0[i] >= 0), 1);
    end

    // Positive saturation and recovery
    in0 = 8'd0;
    in1 = 8'd0;
    do_reset(2);
    run(64);
    wait_phase(0);
    step_to(8'd255);
    run(16 * 220);
    found = 0;
    if (hist0.size() >= 2) begin
      chk("sat_first", hist0[0], 32767);
      chk("sat_second", hist0[1], 32767);
    end else chk("sat_count", hist0.size(), 2);
    for (int i = 1; i < hist0.size(); i++) begin
      chk("sat_mono", int'(hist0[i] <= hist0[i-1]), 1);
      chk("sat_nowrap", int'(hist0[i] >= 0), 1);
      if (hist0[i] < 32767) found = 1;
    end
    chk("sat_decays", found, 1);

    // Negative saturation
    in0 = 8'd255;
    in1 = 8'd255;
    do_reset(2);
    run(64);
    wait_phase(0);
    step_to(8'd0);
    run(64);
    if (hist0.size() >= 1) chk("negsat_first", hist0[0], -32768);
    else chk("negsat_count", hist0.size(), 1);

    // Alternating input with in1 muted, then reset mid-window
    dcbyp = 1'b1;
    mute  = 2'b10;
    in0   = 8'd0;
    in1   = 8'd50;
    alt   = 1'b1;
    do_reset(2);
    run(80);
    chk("mute_val", last_val[0], -9984);
    wait_phase(7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hist0.delete();
    run(40);
    if (hist0.size() >= 1) chk("abort_val", hist0[0], -9984);
    else chk("abort_count", hist0.size(), 1);
    alt = 1'b0;

    // Random traffic with live mute/bypass changes and rare resets
    mute  = 2'b00;
    dcbyp = 1'b0;
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      tick();
      in0 = 8'($urandom);
      in1 = 8'($urandom);
      if ($urandom_range(0, 49) == 0) mute = 2'($urandom);
      if ($urandom_range(0, 99) == 0) dcbyp = ~dcbyp;
      reset = ($urandom_range(0, 799) == 0);
    end
    reset = 1'b0;
    run(300);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
